decoder_3x8_pulse: RTL
======================

# decoder_3x8_pulse

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It takes a 3-bit binary code and drives the matching one-hot line for exactly HOLD_CYCLES clocks, then reports completion. It is the inverse of the team's 8x3 binary encoder and sits on the control side, driving select or strobe lines from compact binary commands.

## Interface
- HOLD_CYCLES, 4: clocks each one-hot output stays asserted; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low blocks acceptance and aborts an active hold.
- bin_in  input  3  binary code to decode.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a code.
- dec_out  output  8  registered one-hot output; all-zero when idle.
- busy  output  1  a hold is in progress.
- done  output  1  one-cycle pulse when a hold completes normally.
- par_in  input  1  odd-parity bit over bin_in; present only with DEC_PARITY_EN.
- err  output  1  one-cycle pulse on a parity failure; present only with DEC_PARITY_EN.

## Operation
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, dec_out=8'h00, counter=0, busy=0, done=0, err=0.
- in_ready = (state==IDLE) & en. It is combinational from the state register and en.
- State IDLE: dec_out=0.
  - A transfer happens when in_valid & in_ready are both high at a rising edge.
  - On a transfer: dec_out <= 8'h01 << bin_in, counter <= HOLD_CYCLES-1, next state HOLD.
- State HOLD: busy=1 and dec_out holds its value.
  - If en=0: dec_out <= 0 and state <= IDLE (abort). done is not pulsed.
  - Else if counter==0: dec_out <= 0, state <= IDLE, and done is pulsed high for the following cycle.
  - Else: counter decrements by 1.
- Every accepted code is followed by at least one all-zero cycle on dec_out. Back-to-back identical codes therefore produce distinguishable pulses.
- The counter is ceil(log2(HOLD_CYCLES+1)) bits wide and unsigned. It never wraps, because it is only loaded on a transfer.
- dec_out is always one-hot or all-zero. A multi-hot value is a bug.
- in_valid while not ready: bin_in is ignored. The source must hold it stable until a transfer occurs.

## Timing
- Transfer at edge T: dec_out is valid after edge T and stays asserted through edge T+HOLD_CYCLES. It returns to zero after that edge.
- done is high during the cycle after edge T+HOLD_CYCLES, which is the same cycle dec_out reads 0.
- in_ready returns in that same cycle. The next transfer is at the earliest at edge T+HOLD_CYCLES+1.
- Sustained throughput: one code every HOLD_CYCLES+1 clocks.
- rst asserted mid-hold: all outputs clear immediately, without waiting for a clock edge.
- en falls in the same cycle as the final hold cycle: abort takes priority and done stays 0.

## Configuration
- DEC_PARITY_EN defined: par_in and err ports exist.
  - A transfer with ^{bin_in,par_in}==0 (even parity) is consumed: the handshake completes, but dec_out stays 0 and the state stays IDLE.
  - err pulses high for one cycle after that edge.
- DEC_PARITY_EN undefined: no parity ports, and every transfer is decoded.

## Structure
- Package decoder_pkg holds:
  - CODE_W=3 and OUT_W=8.
  - The state typedef dec_state_t {IDLE, HOLD}.
- Sub-module onehot_dec_3x8 is the pure combinational binary-to-one-hot map. The top level registers its output.

## Test plan
- Reset, then accept codes 0..7 in order with HOLD_CYCLES=4 -> dec_out goes 01,02,...,80. Each value is held 4 clocks with a 1-clock zero gap, and done pulses 8 times.
- in_valid held high with bin_in=3 -> 08 for 4 clocks, 00 for 1 clock, then 08 again. in_ready is low throughout each hold.
- Code 5 accepted, then en dropped after 2 hold cycles -> dec_out=0 on the next edge, no done, and in_ready returns once en=1.
- Assert rst on the 2nd hold cycle of code 6 -> dec_out=00 and busy=0 immediately, before any clock edge. Normal operation resumes after rst is released.
- Build with HOLD_CYCLES=1, send codes 7 then 7 -> 80 for 1 clock, 00 for 1 clock, 80 for 1 clock.
- With DEC_PARITY_EN, send bin_in=3 with par_in=0 (even parity) -> err pulses and dec_out stays 00. Then send bin_in=3 with par_in=1 -> dec_out=08.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths, state encoding and parity helper for the 3-to-8 pulse decoder.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef logic [0:0] dec_state_t;
  localparam dec_state_t IDLE = 1'b0;
  localparam dec_state_t HOLD = 1'b1;

  // Odd parity over code and parity bit: true when the total count of ones is odd.
  function automatic logic odd_parity_ok(input logic [CODE_W-1:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/decoder_3x8_pulse_onehot.sv
// Pure combinational binary-to-one-hot map used by decoder_3x8_pulse.
module onehot_dec_3x8
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] bin,
  output logic [OUT_W-1:0]  onehot
);

  // Table form keeps the output provably one-hot for every legal code.
  always_comb begin
    onehot = 8'h00;
    case (bin)
      3'd0:    onehot = 8'h01;
      3'd1:    onehot = 8'h02;
      3'd2:    onehot = 8'h04;
      3'd3:    onehot = 8'h08;
      3'd4:    onehot = 8'h10;
      3'd5:    onehot = 8'h20;
      3'd6:    onehot = 8'h40;
      3'd7:    onehot = 8'h80;
      default: onehot = 8'h00;
    endcase
  end

endmodule

// File: rtl/decoder_3x8_pulse.sv
// Registered 3-to-8 one-hot decoder with valid/ready input and programmable hold time.
// Optional odd-parity checking on the input code is enabled by defining DEC_PARITY_EN.
module decoder_3x8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] bin_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  dec_out,
  output logic              busy,
`ifdef DEC_PARITY_EN
  input  logic              par_in,
  output logic              err,
`endif
  output logic              done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  dec_state_t           state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [OUT_W-1:0]     dec_r, dec_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 err_r, err_s;
  logic [OUT_W-1:0]     onehot_s;
  logic                 xfer_s;
  logic                 par_ok_s;

  onehot_dec_3x8 u_onehot (
    .bin    (bin_in),
    .onehot (onehot_s)
  );

  assign in_ready = (state_r == IDLE) & en;
  assign xfer_s   = in_valid & in_ready;

`ifdef DEC_PARITY_EN
  assign par_ok_s = odd_parity_ok(bin_in, par_in);
  assign err      = err_r;
`else
  assign par_ok_s = 1'b1;
`endif

  assign dec_out = dec_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Next-state logic: an even-parity transfer is consumed without entering HOLD.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dec_s   = dec_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        dec_s  = 8'h00;
        busy_s = 1'b0;
        if (xfer_s) begin
          if (par_ok_s) begin
            dec_s   = onehot_s;
            cnt_s   = CNT_W'(HOLD_CYCLES - 1);
            state_s = HOLD;
            busy_s  = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        busy_s = 1'b1;
        // Abort wins over normal completion, so done is never pulsed on an abort.
        if (!en) begin
          dec_s   = 8'h00;
          state_s = IDLE;
          busy_s  = 1'b0;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          dec_s   = 8'h00;
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        dec_s   = 8'h00;
        busy_s  = 1'b0;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      dec_r   <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dec_r   <= dec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

`ifndef DEC_PARITY_EN
  logic unused_err_s;
  assign unused_err_s = err_r;
`endif

endmodule
